// File: rtl/gate_sweep_ctrl_if.sv
// Purpose: bundles the sweep control, gate stimulus/response and result signals.
// Latency: n/a (wiring only).
// Backpressure: none; master is the sequencer, slave is the environment.
interface gate_sweep_ctrl_if #(
    parameter int N_IN = 2
);
    logic              start;
    logic              abort;
    logic [N_IN-1:0]   pattern;
    logic [2:0]        dut_o;
    logic              busy;
    logic              done;
    logic              pass;
    logic [N_IN:0]     err_count;
    logic [N_IN-1:0]   first_err_pat;
    logic [2:0]        first_err_mask;

    modport master (
        input  start, abort, dut_o,
        output pattern, busy, done, pass, err_count, first_err_pat, first_err_mask
    );

    modport slave (
        output start, abort, dut_o,
        input  pattern, busy, done, pass, err_count, first_err_pat, first_err_mask
    );
endinterface

// File: rtl/gate_sweep_ctrl.sv
// Purpose: exhaustive truth-table sweep of three AND gates against a reference AND.
// Latency: 2^N_IN*(SETTLE+1)+1 cycles from accepted start to the done pulse.
// Backpressure: none; start ignored while busy, abort ends a sweep early (no done).
module gate_sweep_ctrl #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    gate_sweep_ctrl_if.master  bus
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE - 1);
    localparam logic [N_IN:0]    ERR_ONE  = (N_IN + 1)'(1);
    localparam logic [N_IN-1:0]  PAT_ONE  = N_IN'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_IN-1:0]    pattern_q, pattern_d;
    logic [N_IN:0]      err_count_q, err_count_d;
    logic [N_IN-1:0]    first_err_pat_q, first_err_pat_d;
    logic [2:0]         first_err_mask_q, first_err_mask_d;
    logic               pass_q, pass_d;

    logic [2:0]         expected;
    logic [2:0]         mask;
    logic               last_pat;

    // Reference AND of the current pattern and per-gate mismatch vector.
    always_comb begin
        expected = {3{&pattern_q}};
        mask     = bus.dut_o ^ expected;
        last_pat = &pattern_q;
    end

    // Next-state and result update logic of the sweep sequencer.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        pattern_d        = pattern_q;
        err_count_d      = err_count_q;
        first_err_pat_d  = first_err_pat_q;
        first_err_mask_d = first_err_mask_q;
        pass_d           = pass_q;

        case (state_q)
            ST_IDLE: begin
                pattern_d = '0;
                // start wins over a simultaneous abort here: abort is not looked at
                if (bus.start) begin
                    err_count_d      = '0;
                    first_err_pat_d  = '0;
                    first_err_mask_d = '0;
                    pass_d           = 1'b0;
                    cnt_d            = CNT_INIT;
                    state_d          = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (bus.abort) begin
                    state_d   = ST_IDLE;
                    pattern_d = '0;
                    pass_d    = 1'b0;
                end else if (cnt_q == '0) begin
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_CHECK: begin
                // The sample is recorded even when abort arrives in the same cycle.
                if (mask != 3'b000) begin
                    err_count_d = err_count_q + ERR_ONE;
                    if (err_count_q == '0) begin
                        first_err_pat_d  = pattern_q;
                        first_err_mask_d = mask;
                    end
                end
                if (bus.abort) begin
                    state_d   = ST_IDLE;
                    pattern_d = '0;
                    pass_d    = 1'b0;
                end else if (last_pat) begin
                    // Verdict includes this final check, visible alongside done.
                    state_d = ST_DONE;
                    pass_d  = (err_count_d == '0);
                end else begin
                    pattern_d = pattern_q + PAT_ONE;
                    cnt_d     = CNT_INIT;
                    state_d   = ST_WAIT;
                end
            end

            ST_DONE: begin
                // abort is ignored here; the sweep completes normally
                state_d   = ST_IDLE;
                pattern_d = '0;
            end

            default: begin
                state_d   = ST_IDLE;
                pattern_d = '0;
            end
        endcase
    end

    // State and result registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            cnt_q            <= '0;
            pattern_q        <= '0;
            err_count_q      <= '0;
            first_err_pat_q  <= '0;
            first_err_mask_q <= '0;
            pass_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            pattern_q        <= pattern_d;
            err_count_q      <= err_count_d;
            first_err_pat_q  <= first_err_pat_d;
            first_err_mask_q <= first_err_mask_d;
            pass_q           <= pass_d;
        end
    end

    assign bus.pattern        = pattern_q;
    assign bus.busy           = (state_q != ST_IDLE);
    assign bus.done           = (state_q == ST_DONE);
    assign bus.pass           = pass_q;
    assign bus.err_count      = err_count_q;
    assign bus.first_err_pat  = first_err_pat_q;
    assign bus.first_err_mask = first_err_mask_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Purpose: randomized and directed checking of gate_sweep_ctrl against a sweep-level model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_gate_sweep_ctrl;

    localparam int N      = 2;
    localparam int S      = 2;
    localparam int NPAT   = 1 << N;
    localparam int PER    = S + 1;
    localparam int LAST   = NPAT * PER;
    localparam int DONE_C = LAST + 1;

    logic clk;
    logic rst_n;
    logic [2:0] fault_tbl [NPAT];

    int n_tests;
    int n_fail;

    // Results the block should hold between sweeps.
    int last_err;
    int last_fp;
    int last_fm;
    int last_pass;

    gate_sweep_ctrl_if #(.N_IN(N)) bus ();

    gate_sweep_ctrl #(.N_IN(N), .SETTLE(S)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Three gates: ideal AND with a per-pattern fault overlay.
    always_comb bus.dut_o = {3{&bus.pattern}} ^ fault_tbl[bus.pattern];

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_results(input string pfx);
        chk({pfx, "_pass"}, int'(bus.pass), last_pass);
        chk({pfx, "_err_count"}, int'(bus.err_count), last_err);
        chk({pfx, "_first_pat"}, int'(bus.first_err_pat), last_fp);
        chk({pfx, "_first_mask"}, int'(bus.first_err_mask), last_fm);
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_pattern"}, int'(bus.pattern), 0);
        chk({pfx, "_busy"}, int'(bus.busy), 0);
        chk({pfx, "_done"}, int'(bus.done), 0);
        chk({pfx, "_pass"}, int'(bus.pass), 0);
        chk({pfx, "_err_count"}, int'(bus.err_count), 0);
        chk({pfx, "_first_pat"}, int'(bus.first_err_pat), 0);
        chk({pfx, "_first_mask"}, int'(bus.first_err_mask), 0);
    endtask

    // Idle cycles: stray aborts must do nothing, results must hold.
    task automatic idle_chk(input int n);
        for (int i = 0; i < n; i++) begin
            bus.abort = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            bus.abort = 1'b0;
            chk("idle_busy", int'(bus.busy), 0);
            chk("idle_done", int'(bus.done), 0);
            chk("idle_pattern", int'(bus.pattern), 0);
            chk_results("idle");
        end
    endtask

    // One sweep from the current cycle (which becomes edge 0).
    // abort_at: cycle in which abort is raised (0 = none); st_a/st_b: extra start pulses;
    // rst_at: cycle in which reset is pulled mid-cycle (0 = none).
    task automatic sweep(input int abort_at, input int st_a, input int st_b,
                         input int rst_at, input bit abort_w_start);
        bit aborted;
        int e_err, e_fp, e_fm, e_pass, end_c, exp_pat;
        aborted = (abort_at >= 1) && (abort_at <= LAST);
        e_err = 0; e_fp = 0; e_fm = 0;
        for (int p = 0; p < NPAT; p++) begin
            if (!aborted || ((p + 1) * PER <= abort_at)) begin
                if (fault_tbl[p] != 3'b000) begin
                    if (e_err == 0) begin
                        e_fp = p;
                        e_fm = int'(fault_tbl[p]);
                    end
                    e_err++;
                end
            end
        end
        e_pass = (!aborted && e_err == 0) ? 1 : 0;
        end_c  = aborted ? abort_at + 1 : DONE_C + 1;

        bus.start = 1'b1;
        bus.abort = abort_w_start;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;

        for (int k = 1; k <= end_c; k++) begin
            if (k == rst_at) begin
                #2 rst_n = 1'b0;
                #1;
                chk_all_zero("rst_async");
                #2 rst_n = 1'b1;
                @(posedge clk); #1;
                last_err = 0; last_fp = 0; last_fm = 0; last_pass = 0;
                return;
            end
            if (k < end_c) begin
                exp_pat = (k <= LAST) ? (k - 1) / PER : NPAT - 1;
                chk("pattern", int'(bus.pattern), exp_pat);
                chk("busy", int'(bus.busy), 1);
                chk("done", int'(bus.done), (k == DONE_C) ? 1 : 0);
                if (k < DONE_C) chk("pass_cleared", int'(bus.pass), 0);
                bus.start = (k == st_a) || (k == st_b);
                bus.abort = (k == abort_at);
                @(posedge clk); #1;
                bus.start = 1'b0;
                bus.abort = 1'b0;
            end else begin
                last_err = e_err; last_fp = e_fp; last_fm = e_fm; last_pass = e_pass;
                chk("end_busy", int'(bus.busy), 0);
                chk("end_pattern", int'(bus.pattern), 0);
                chk("end_done", int'(bus.done), 0);
                chk_results("end");
            end
        end
    endtask

    task automatic set_faults_zero();
        for (int p = 0; p < NPAT; p++) fault_tbl[p] = 3'b000;
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        last_err = 0; last_fp = 0; last_fm = 0; last_pass = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        set_faults_zero();

        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        idle_chk(3);

        // All three gates correct.
        sweep(0, 0, 0, 0, 1'b0);
        chk("all_ok_pass", int'(bus.pass), 1);
        idle_chk(2);

        // Gate-level output stuck at 1.
        for (int p = 0; p < NPAT; p++) fault_tbl[p] = (p == NPAT - 1) ? 3'b000 : 3'b100;
        sweep(0, 0, 0, 0, 1'b0);

        // Behavioural output inverted only at the last pattern.
        set_faults_zero();
        fault_tbl[NPAT - 1] = 3'b001;
        sweep(0, 0, 0, 0, 1'b0);

        // Abort while waiting on pattern 1, then a clean full sweep.
        fault_tbl[0] = 3'b010;
        sweep(5, 0, 0, 0, 1'b0);
        idle_chk(2);
        set_faults_zero();
        sweep(0, 0, 0, 0, 1'b0);

        // Start re-pulsed while busy (incl. the done cycle), then back-to-back sweep.
        sweep(0, 4, DONE_C, 0, 1'b0);
        sweep(0, 0, 0, 0, 1'b0);

        // Start and abort together in idle: start wins.
        sweep(0, 0, 0, 0, 1'b1);

        // Abort in the done cycle is ignored; abort on the last check still counts it.
        fault_tbl[NPAT - 1] = 3'b110;
        sweep(DONE_C, 0, 0, 0, 1'b0);
        sweep(LAST, 0, 0, 0, 1'b0);

        // Asynchronous reset mid-sweep with errors already recorded.
        fault_tbl[0] = 3'b011;
        sweep(0, 0, 0, 7, 1'b0);
        idle_chk(4);
        set_faults_zero();
        sweep(0, 0, 0, 0, 1'b0);

        // Randomized fault tables, aborts and stray starts.
        for (int r = 0; r < 30; r++) begin
            int ab;
            for (int p = 0; p < NPAT; p++)
                fault_tbl[p] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, DONE_C)) : 0;
            sweep(ab, int'($urandom_range(1, DONE_C)), 0, 0, 1'($urandom_range(0, 1)));
            idle_chk(int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
